// File: rtl/sync_fifo_pkg.sv
// Shared types for the synchronous FIFO: per-cycle access classification.
package sync_fifo_pkg;

  // Accepted-access kind for one clock edge, {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } op_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO control: pointers, occupancy, registered flags and read-data register.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_wr_en,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_qout,
  output logic                       o_qvalid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic [WIDTH-1:0]  r_qout;
  logic              r_qvalid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_rd_acc;
  logic              w_wr_acc;
  op_e               w_op;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [WIDTH-1:0]  w_rdata;

  // A write into a full FIFO is legal only when the same edge frees a slot.
  assign w_rd_acc = i_rd_en && !r_empty;
  assign w_wr_acc = i_wr_en && (!r_full || w_rd_acc);
  assign w_op     = op_e'({w_wr_acc, w_rd_acc});

  always_comb begin
    w_count_nxt = r_count;
    case (w_op)
      OP_WRITE: w_count_nxt = r_count + CNT_W'(1);
      OP_READ:  w_count_nxt = r_count - CNT_W'(1);
      default:  w_count_nxt = r_count;
    endcase
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clock),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (i_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_qout      <= '0;
      r_qvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_rd_acc) begin
        r_rptr <= r_rptr + ADDR_W'(1);
        r_qout <= w_rdata;
      end
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == FULL_CNT);
      r_empty     <= (w_count_nxt == '0);
      r_qvalid    <= w_rd_acc;
      r_overflow  <= i_wr_en && !w_wr_acc;
      r_underflow <= i_rd_en && !w_rd_acc;
    end
  end

  assign o_qout      = r_qout;
  assign o_qvalid    = r_qvalid;
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 1, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of storage entries; power of two, 2..256.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 CLOCK  input  1  sole clock; all state changes on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 DATA  input  WIDTH  write data.
REQ-007 WR_EN  input  1  write request.
REQ-008 RD_EN  input  1  read (pop) request.
REQ-009 QOUT  output  WIDTH  registered read data; feeds the downstream pDFF stage.
REQ-010 QVALID  output  1  high for exactly one cycle when QOUT carries newly popped data.
REQ-011 FULL  output  1  registered; high when count equals DEPTH.
REQ-012 EMPTY  output  1  registered; high when count equals 0.
REQ-013 COUNT  output  $clog2(DEPTH)+1  registered occupancy, 0..DEPTH.
REQ-014 OVERFLOW  output  1  one-cycle pulse: write rejected.
REQ-015 UNDERFLOW  output  1  one-cycle pulse: read rejected.

Function
REQ-016 The FIFO shall accept a write on a rising edge when WR_EN=1 and (FULL=0, or RD_EN=1 with the read accepted).
REQ-017 The FIFO shall accept a read on a rising edge when RD_EN=1 and EMPTY=0.
REQ-018 An accepted read shall load the head entry into QOUT and assert QVALID on the cycle after the RD_EN edge (latency 1).
REQ-019 QOUT shall hold its last value when no read is accepted; QVALID shall be 0.
REQ-020 Data shall leave in strict write order; no entry shall be lost or duplicated.
REQ-021 Write pointer and read pointer shall each be ADDR_W=$clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 COUNT shall be +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write or on no access.
REQ-023 FULL and EMPTY shall be derived from next-state COUNT and registered, so they are valid in the same cycle as COUNT.
REQ-024 Full with WR_EN=1 and RD_EN=1: both shall be accepted; COUNT stays DEPTH; FULL stays 1.
REQ-025 Empty with WR_EN=1 and RD_EN=1: the write shall be accepted, the read rejected; UNDERFLOW shall pulse; no write-to-read bypass.
REQ-026 WR_EN=1 while full without an accepted read shall pulse OVERFLOW and leave storage, pointers and COUNT unchanged.
REQ-027 RD_EN=1 while empty shall pulse UNDERFLOW and leave QOUT, pointers and COUNT unchanged.

Reset
REQ-028 Asserting RESET shall immediately set pointers=0, COUNT=0, EMPTY=1, FULL=0, QOUT=0, QVALID=0, OVERFLOW=0, UNDERFLOW=0.
REQ-029 Storage contents need not be reset; stale entries shall never appear on QOUT.
REQ-030 Reset mid-operation shall discard all stored entries; the first read after release shall return the first word written after release.
REQ-031 Accesses shall be ignored while RESET=1.

Structure
REQ-032 No shared package is required: ADDR_W and the COUNT width shall be derived locally from DEPTH.
REQ-033 Storage shall be a sub-module fifo_mem: one write port and one read port, with no reset on the array.
REQ-034 Control (pointers, COUNT, flags, QOUT register) shall reside in sync_fifo.

Verification
REQ-035 DEPTH=8, WIDTH=8: write 0x01..0x08 -> FULL=1 and COUNT=8 after the 8th edge; read 8 times -> QOUT 0x01..0x08 with QVALID each cycle; then EMPTY=1.
REQ-036 Full, write 0xAA with RD_EN=0 -> OVERFLOW pulse; COUNT stays 8; subsequent reads do not return 0xAA.
REQ-037 Empty, RD_EN=1 -> UNDERFLOW pulse; QVALID=0; QOUT unchanged.
REQ-038 Full, WR_EN=RD_EN=1 writing 0x55 -> oldest word popped; COUNT=8; 0x55 emerges after 7 further reads.
REQ-039 Empty, WR_EN=RD_EN=1 writing 0x33 -> COUNT=1, UNDERFLOW pulse; next read returns 0x33.
REQ-040 Write 5 words, assert RESET asynchronously mid-cycle -> flags and COUNT reset immediately; write 0x77, read -> 0x77.
